// File: rtl/sprite_pixel_scheduler.sv
// Sprite pixel scheduler: per-pixel hit test and sprite-ROM addressing for the duck and
// dog sprites, duck-over-dog arbitration, and select/valid flags delayed to line up with
// the synchronous sprite-ROM and palette reads. Sprite positions from game logic are
// staged in shadow registers and only become active at a frame boundary.
module sprite_pixel_scheduler #(
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480,
   parameter int unsigned DUCK_W   = 64,
   parameter int unsigned DUCK_H   = 64,
   parameter int unsigned DOG_W    = 64,
   parameter int unsigned DOG_H    = 48,
   parameter int unsigned ROM_LAT  = 1,
   parameter int unsigned PAL_LAT  = 1
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        frame_start,
   input  logic        upd_req,
   input  logic [9:0]  upd_duck_x,
   input  logic [9:0]  upd_duck_y,
   input  logic [9:0]  upd_dog_x,
   input  logic [9:0]  upd_dog_y,
   input  logic        upd_duck_en,
   input  logic        upd_dog_en,
   output logic        upd_ack,
   output logic [15:0] duck_addr,
   output logic [13:0] dog_addr,
   output logic        is_duck,
   output logic        is_dog,
   output logic        pix_sprite
);

   localparam int unsigned FLAG_D = ROM_LAT + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PEND    = 2'd1,
      S_APPLY   = 2'd2,
      S_WAITLOW = 2'd3
   } state_t;

   state_t state_q, state_d;
   logic   capture_s;
   logic   upd_ack_q, upd_ack_d;

   // Shadow (captured) and active (in-use) sprite positions.
   logic [9:0] sh_duck_x_q, sh_duck_y_q, sh_dog_x_q, sh_dog_y_q;
   logic       sh_duck_en_q, sh_dog_en_q;
   logic [9:0] duck_x_q, duck_y_q, dog_x_q, dog_y_q;
   logic       duck_en_q, dog_en_q;

   // Hit test / addressing.
   logic [10:0] x_s, y_s, duck_dx_s, duck_dy_s, dog_dx_s, dog_dy_s;
   logic        on_screen_s, duck_hit_s, dog_hit_s, dog_sel_s;
   logic [15:0] duck_lin_s, duck_addr_d, duck_addr_q;
   logic [13:0] dog_lin_s, dog_addr_d, dog_addr_q;

   // Flag delay lines.
   logic [FLAG_D-1:0]  duck_sh_q, dog_sh_q;
   logic [PAL_LAT-1:0] pix_sh_q;
   logic               pix_in_s;

   // Update FSM next-state: capture on request, apply at frame start, wait for request drop.
   always_comb begin
      state_d   = state_q;
      capture_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (upd_req) begin
               state_d   = S_PEND;
               capture_s = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PEND: begin
            if (frame_start) begin
               state_d = S_APPLY;
            end else begin
               state_d = S_PEND;
            end
         end
         S_APPLY: begin
            state_d = S_WAITLOW;
         end
         S_WAITLOW: begin
            if (!upd_req) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WAITLOW;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      upd_ack_d = (state_d == S_APPLY);
   end

   // FSM state and registered ack (high exactly while in APPLY).
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= S_IDLE;
         upd_ack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         upd_ack_q <= upd_ack_d;
      end
   end

   // Shadow registers load on capture; active registers load only when leaving APPLY.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sh_duck_x_q  <= 10'd0;
         sh_duck_y_q  <= 10'd0;
         sh_dog_x_q   <= 10'd0;
         sh_dog_y_q   <= 10'd0;
         sh_duck_en_q <= 1'b0;
         sh_dog_en_q  <= 1'b0;
         duck_x_q     <= 10'd0;
         duck_y_q     <= 10'd0;
         dog_x_q      <= 10'd0;
         dog_y_q      <= 10'd0;
         duck_en_q    <= 1'b0;
         dog_en_q     <= 1'b0;
      end else begin
         if (capture_s) begin
            sh_duck_x_q  <= upd_duck_x;
            sh_duck_y_q  <= upd_duck_y;
            sh_dog_x_q   <= upd_dog_x;
            sh_dog_y_q   <= upd_dog_y;
            sh_duck_en_q <= upd_duck_en;
            sh_dog_en_q  <= upd_dog_en;
         end
         if (state_q == S_APPLY) begin
            duck_x_q  <= sh_duck_x_q;
            duck_y_q  <= sh_duck_y_q;
            dog_x_q   <= sh_dog_x_q;
            dog_y_q   <= sh_dog_y_q;
            duck_en_q <= sh_duck_en_q;
            dog_en_q  <= sh_dog_en_q;
         end
      end
   end

   // Hit test in 11-bit unsigned arithmetic; the >= guards make the differences wrap-free.
   always_comb begin
      x_s         = {1'b0, DrawX};
      y_s         = {1'b0, DrawY};
      on_screen_s = (x_s < 11'(SCREEN_W)) && (y_s < 11'(SCREEN_H));
      duck_dx_s   = x_s - {1'b0, duck_x_q};
      duck_dy_s   = y_s - {1'b0, duck_y_q};
      dog_dx_s    = x_s - {1'b0, dog_x_q};
      dog_dy_s    = y_s - {1'b0, dog_y_q};
      duck_hit_s  = duck_en_q && on_screen_s
                    && (x_s >= {1'b0, duck_x_q}) && (32'(duck_dx_s) < DUCK_W)
                    && (y_s >= {1'b0, duck_y_q}) && (32'(duck_dy_s) < DUCK_H);
      dog_hit_s   = dog_en_q && on_screen_s
                    && (x_s >= {1'b0, dog_x_q}) && (32'(dog_dx_s) < DOG_W)
                    && (y_s >= {1'b0, dog_y_q}) && (32'(dog_dy_s) < DOG_H);
      dog_sel_s   = dog_hit_s && !duck_hit_s;
      duck_lin_s  = 16'(duck_dy_s) * 16'(DUCK_W) + 16'(duck_dx_s);
      dog_lin_s   = 14'(dog_dy_s) * 14'(DOG_W) + 14'(dog_dx_s);
      if (duck_hit_s) begin
         duck_addr_d = duck_lin_s;
      end else begin
         duck_addr_d = 16'd0;
      end
      if (dog_sel_s) begin
         dog_addr_d = dog_lin_s;
      end else begin
         dog_addr_d = 14'd0;
      end
      pix_in_s = duck_sh_q[ROM_LAT] | dog_sh_q[ROM_LAT];
   end

   // Free-running address registers and flag delay lines (no stalls).
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         duck_addr_q <= 16'd0;
         dog_addr_q  <= 14'd0;
         duck_sh_q   <= '0;
         dog_sh_q    <= '0;
         pix_sh_q    <= '0;
      end else begin
         duck_addr_q <= duck_addr_d;
         dog_addr_q  <= dog_addr_d;
         duck_sh_q   <= FLAG_D'({duck_sh_q, duck_hit_s});
         dog_sh_q    <= FLAG_D'({dog_sh_q, dog_sel_s});
         pix_sh_q    <= PAL_LAT'({pix_sh_q, pix_in_s});
      end
   end

   assign upd_ack    = upd_ack_q;
   assign duck_addr  = duck_addr_q;
   assign dog_addr   = dog_addr_q;
   assign is_duck    = duck_sh_q[ROM_LAT];
   assign is_dog     = dog_sh_q[ROM_LAT];
   assign pix_sprite = pix_sh_q[PAL_LAT-1];

endmodule

// File: tb/tb_sprite_pixel_scheduler.sv
// Scoreboard bench for sprite_pixel_scheduler: stimulus pushes expected values tagged
// with the cycle they are due; a monitor compares them on the falling clock edge.
module tb_sprite_pixel_scheduler;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [9:0]  DrawX = 10'd0, DrawY = 10'd0;
   logic        frame_start = 1'b0, upd_req = 1'b0;
   logic [9:0]  upd_duck_x = 10'd0, upd_duck_y = 10'd0, upd_dog_x = 10'd0, upd_dog_y = 10'd0;
   logic        upd_duck_en = 1'b0, upd_dog_en = 1'b0;
   logic        upd_ack, is_duck, is_dog, pix_sprite;
   logic [15:0] duck_addr;
   logic [13:0] dog_addr;

   sprite_pixel_scheduler dut (
      .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
      .frame_start(frame_start), .upd_req(upd_req),
      .upd_duck_x(upd_duck_x), .upd_duck_y(upd_duck_y),
      .upd_dog_x(upd_dog_x), .upd_dog_y(upd_dog_y),
      .upd_duck_en(upd_duck_en), .upd_dog_en(upd_dog_en),
      .upd_ack(upd_ack), .duck_addr(duck_addr), .dog_addr(dog_addr),
      .is_duck(is_duck), .is_dog(is_dog), .pix_sprite(pix_sprite)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      int          kind;   // 0 duck_addr 1 dog_addr 2 is_duck 3 is_dog 4 pix_sprite 5 upd_ack
      logic [15:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic expect_at(input int due, input int kind, input logic [15:0] val, input string name);
      exp_t e;
      e.due = due; e.kind = kind; e.val = val; e.name = name;
      sb.push_back(e);
   endtask

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge Clk) begin
      logic [15:0] act;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            case (sb[i].kind)
               0:       act = duck_addr;
               1:       act = {2'b00, dog_addr};
               2:       act = {15'd0, is_duck};
               3:       act = {15'd0, is_dog};
               4:       act = {15'd0, pix_sprite};
               default: act = {15'd0, upd_ack};
            endcase
            checks++;
            if (act !== sb[i].val) begin
               errors++;
               $display("FAIL %s (cycle %0d): got %0d, expected %0d", sb[i].name, cyc, act, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   // Drive one pixel and queue its hand-computed results at their pipeline latencies.
   task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [15:0] da,
                      input logic [15:0] ga, input logic d, input logic g, input string tag);
      DrawX = x;
      DrawY = y;
      expect_at(cyc + 1, 0, da, {tag, ".duck_addr"});
      expect_at(cyc + 1, 1, ga, {tag, ".dog_addr"});
      expect_at(cyc + 2, 2, {15'd0, d}, {tag, ".is_duck"});
      expect_at(cyc + 2, 3, {15'd0, g}, {tag, ".is_dog"});
      expect_at(cyc + 3, 4, {15'd0, d | g}, {tag, ".pix_sprite"});
      @(negedge Clk);
   endtask

   task automatic expect_zero_outputs(input int due, input string tag);
      for (int k = 0; k < 6; k++) expect_at(due, k, 16'd0, {tag, ".out0"});
   endtask

   // Full handshake: request, frame_start, single ack, request dropped.
   task automatic do_update(input logic [9:0] dx, input logic [9:0] dy, input logic [9:0] gx,
                            input logic [9:0] gy, input logic de, input logic ge, input string tag);
      upd_duck_x = dx; upd_duck_y = dy; upd_dog_x = gx; upd_dog_y = gy;
      upd_duck_en = de; upd_dog_en = ge;
      upd_req = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      frame_start = 1'b1;
      expect_at(cyc + 1, 5, 16'd1, {tag, ".ack"});
      for (int k = 2; k <= 5; k++) expect_at(cyc + k, 5, 16'd0, {tag, ".ack_once"});
      @(negedge Clk);
      frame_start = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      upd_req = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
   endtask

   initial begin
      // Reset state.
      repeat (2) @(negedge Clk);
      expect_zero_outputs(cyc + 1, "reset");
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      // 1: single duck.
      do_update(10'd100, 10'd50, 10'd0, 10'd0, 1'b1, 1'b0, "t1");
      pix(10'd110, 10'd52, 16'd138, 16'd0, 1'b1, 1'b0, "t1_hit");
      pix(10'd99, 10'd52, 16'd0, 16'd0, 1'b0, 1'b0, "t1_left");

      // 2: overlap, duck has priority; dog alone elsewhere.
      do_update(10'd100, 10'd50, 10'd105, 10'd50, 1'b1, 1'b1, "t2");
      pix(10'd110, 10'd60, 16'd650, 16'd0, 1'b1, 1'b0, "t2_overlap");
      pix(10'd165, 10'd97, 16'd0, 16'd3068, 1'b0, 1'b1, "t2_dog");
      pix(10'd165, 10'd98, 16'd0, 16'd0, 1'b0, 1'b0, "t2_dog_below");

      // 3: screen edges with duck at (600,470), then sprite edges with duck at (500,400).
      do_update(10'd600, 10'd470, 10'd0, 10'd0, 1'b1, 1'b0, "t3a");
      pix(10'd639, 10'd470, 16'd39, 16'd0, 1'b1, 1'b0, "t3_x639");
      pix(10'd640, 10'd470, 16'd0, 16'd0, 1'b0, 1'b0, "t3_x640");
      pix(10'd610, 10'd479, 16'd586, 16'd0, 1'b1, 1'b0, "t3_y479");
      pix(10'd610, 10'd480, 16'd0, 16'd0, 1'b0, 1'b0, "t3_y480");
      do_update(10'd500, 10'd400, 10'd0, 10'd0, 1'b1, 1'b0, "t3b");
      pix(10'd563, 10'd400, 16'd63, 16'd0, 1'b1, 1'b0, "t3_x563");
      pix(10'd564, 10'd400, 16'd0, 16'd0, 1'b0, 1'b0, "t3_x564");
      pix(10'd499, 10'd400, 16'd0, 16'd0, 1'b0, 1'b0, "t3_x499");
      pix(10'd500, 10'd463, 16'd4032, 16'd0, 1'b1, 1'b0, "t3_y463");
      pix(10'd500, 10'd464, 16'd0, 16'd0, 1'b0, 1'b0, "t3_y464");

      // 4: mid-frame request; old position until frame_start; one ack despite held request.
      upd_duck_x = 10'd0; upd_duck_y = 10'd0; upd_duck_en = 1'b1; upd_dog_en = 1'b0;
      upd_req = 1'b1;
      pix(10'd510, 10'd410, 16'd650, 16'd0, 1'b1, 1'b0, "t4_old_a");
      pix(10'd5, 10'd5, 16'd0, 16'd0, 1'b0, 1'b0, "t4_new_miss");
      frame_start = 1'b1;
      expect_at(cyc + 1, 5, 16'd1, "t4.ack");
      for (int k = 2; k <= 8; k++) expect_at(cyc + k, 5, 16'd0, "t4.ack_once");
      pix(10'd510, 10'd410, 16'd650, 16'd0, 1'b1, 1'b0, "t4_old_b");
      frame_start = 1'b0;
      pix(10'd510, 10'd410, 16'd650, 16'd0, 1'b1, 1'b0, "t4_old_c");
      pix(10'd5, 10'd5, 16'd325, 16'd0, 1'b1, 1'b0, "t4_new_hit");
      pix(10'd510, 10'd410, 16'd0, 16'd0, 1'b0, 1'b0, "t4_old_gone");
      repeat (2) @(negedge Clk);
      upd_req = 1'b0;
      repeat (3) @(negedge Clk);

      // 5: request together with frame_start: captured only, applied at next frame_start.
      upd_duck_x = 10'd200; upd_duck_y = 10'd200; upd_duck_en = 1'b1;
      upd_req = 1'b1;
      frame_start = 1'b1;
      for (int k = 1; k <= 4; k++) expect_at(cyc + k, 5, 16'd0, "t5.no_ack");
      @(negedge Clk);
      frame_start = 1'b0;
      pix(10'd210, 10'd210, 16'd0, 16'd0, 1'b0, 1'b0, "t5_pending");
      pix(10'd10, 10'd10, 16'd650, 16'd0, 1'b1, 1'b0, "t5_still_old");
      repeat (2) @(negedge Clk);
      frame_start = 1'b1;
      expect_at(cyc + 1, 5, 16'd1, "t5.ack");
      for (int k = 2; k <= 4; k++) expect_at(cyc + k, 5, 16'd0, "t5.ack_once");
      @(negedge Clk);
      frame_start = 1'b0;
      @(negedge Clk);
      upd_req = 1'b0;
      repeat (2) @(negedge Clk);
      pix(10'd210, 10'd210, 16'd650, 16'd0, 1'b1, 1'b0, "t5_applied");

      // 6: reset while PEND clears outputs at once and drops the pending update.
      upd_duck_x = 10'd0; upd_duck_y = 10'd0;
      upd_req = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      expect_at(cyc + 1, 2, 16'd1, "t6.pre_is_duck");
      expect_at(cyc + 1, 4, 16'd1, "t6.pre_pix");
      @(negedge Clk);
      @(posedge Clk);
      #1;
      Reset_n = 1'b0;
      expect_zero_outputs(cyc, "t6_rst");
      @(negedge Clk);
      upd_req = 1'b0;
      Reset_n = 1'b1;
      @(negedge Clk);
      frame_start = 1'b1;
      for (int k = 1; k <= 5; k++) expect_at(cyc + k, 5, 16'd0, "t6.no_ack");
      @(negedge Clk);
      frame_start = 1'b0;
      pix(10'd210, 10'd210, 16'd0, 16'd0, 1'b0, 1'b0, "t6_disabled");
      pix(10'd5, 10'd5, 16'd0, 16'd0, 1'b0, 1'b0, "t6_no_apply");
      repeat (6) @(negedge Clk);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending expectations, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
